// File: rtl/lb_bank_pkg.sv
// Shared definitions for the local-bus register bank: region bases,
// the region selector and the access-error causes.
package lb_bank_pkg;

  localparam logic [7:0] CFG_BASE   = 8'h00;
  localparam logic [7:0] STAT_BASE  = 8'h40;
  localparam logic [7:0] ID_ADDR    = 8'h80;
  localparam logic [7:0] CNT_ADDR   = 8'h81;
  localparam logic [7:0] ERR_ADDR   = 8'h82;
  localparam logic [7:0] PULSE_ADDR = 8'hC0;

  localparam int REGION_W = 3;

  typedef enum logic [REGION_W-1:0] {
    RG_NONE,
    RG_CFG,
    RG_STAT,
    RG_ID,
    RG_CNT,
    RG_ERR,
    RG_PULSE
  } region_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_WR_RO,
    ERR_RD_UNMAPPED,
    ERR_RD_WR_BOTH
  } err_cause_e;

  // Any nonzero addr[15:8] pushes the access into the unmapped space.
  function automatic region_e decode(input logic [15:0] a16,
                                     input int cfg_cnt,
                                     input int stat_cnt);
    logic [7:0] a;
    a = a16[7:0];
    if (a16[15:8] != 8'h00)  return RG_NONE;
    if (a < STAT_BASE)       return (int'(a - CFG_BASE) < cfg_cnt) ? RG_CFG : RG_NONE;
    if (a < ID_ADDR)         return (int'(a - STAT_BASE) < stat_cnt) ? RG_STAT : RG_NONE;
    if (a == ID_ADDR)        return RG_ID;
    if (a == CNT_ADDR)       return RG_CNT;
    if (a == ERR_ADDR)       return RG_ERR;
    if (a == PULSE_ADDR)     return RG_PULSE;
    return RG_NONE;
  endfunction

endpackage

// File: rtl/lb_rd_pipe.sv
// Fixed-length data delay line for read data, with synchronous
// active-low clear; a length of 0 is a plain passthrough.
module lb_rd_pipe #(
  parameter int len   = 2,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  generate
    if (len == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [width-1:0] stage_q [len];

      // NOTE: the stages are reset on purpose: a read in flight at reset
      // must come out as 0, not as stale data.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < len; i++) stage_q[i] <= '0;
        end else begin
          // NOTE: non-blocking so each stage takes its neighbour's old value.
          stage_q[0] <= d;
          for (int i = 1; i < len; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[len-1];
    end
  endgenerate

endmodule

// File: rtl/lb_reg_bank.sv
// Local-bus register bank behind the UDP memory gateway: config, status,
// pulse, counters and sticky error, with a fixed read latency.
module lb_reg_bank
  import lb_bank_pkg::*;
#(
  parameter int          read_pipe_len = 3,
  parameter logic [7:0]  page          = 8'h00,
  parameter int          n_cfg         = 8,
  parameter int          n_stat        = 8,
  parameter logic [31:0] bank_id       = 32'h4C425242
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           addr,
  input  logic                  control_strobe,
  input  logic                  control_rd,
  input  logic                  control_write,
  input  logic [31:0]           data_out,
  output logic [31:0]           data_in,
  output logic [n_cfg*32-1:0]   cfg_out,
  input  logic [n_stat*32-1:0]  stat_in,
  output logic [31:0]           pulse_out,
  output logic                  err_flag
);

  logic                hit, is_rd, is_wr;
  logic [5:0]          idx;
  region_e             region;
  err_cause_e          err_cause;
  logic [31:0]         rd_mux;
  logic [31:0]         stage1_q;
  logic [15:0]         rd_count, wr_count;
  logic [n_cfg*32-1:0] cfg_q;

  assign idx = addr[5:0];

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    hit       = control_strobe && (addr[23:16] == page);
    is_rd     = hit && control_rd;
    is_wr     = hit && !control_rd;
    region    = decode(addr[15:0], n_cfg, n_stat);
    rd_mux    = '0;
    err_cause = ERR_NONE;

    case (region)
      RG_CFG:  for (int k = 0; k < n_cfg; k++)  if (idx == 6'(k)) rd_mux = cfg_q[32*k +: 32];
      RG_STAT: for (int k = 0; k < n_stat; k++) if (idx == 6'(k)) rd_mux = stat_in[32*k +: 32];
      RG_ID:   rd_mux = bank_id;
      RG_CNT:  rd_mux = {rd_count, wr_count};
      RG_ERR:  rd_mux = {31'd0, err_flag};
      default: rd_mux = '0;
    endcase

    if (is_rd && control_write)
      err_cause = ERR_RD_WR_BOTH;
    else if (is_rd && region == RG_NONE)
      err_cause = ERR_RD_UNMAPPED;
    else if (is_wr && !(region inside {RG_CFG, RG_ERR, RG_PULSE}))
      err_cause = ERR_WR_RO;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      pulse_out <= '0;
      err_flag  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
      stage1_q  <= '0;
    end else begin
      pulse_out <= (is_wr && region == RG_PULSE) ? data_out : '0;

      if (is_wr && region == RG_CFG)
        for (int k = 0; k < n_cfg; k++)
          if (idx == 6'(k)) cfg_q[32*k +: 32] <= data_out;

      // Holding the first stage between reads keeps data_in stable downstream.
      if (is_rd) begin
        stage1_q <= rd_mux;
        rd_count <= rd_count + 16'd1;
      end
      if (is_wr) wr_count <= wr_count + 16'd1;

      if (err_cause != ERR_NONE)
        err_flag <= 1'b1;
      else if (is_wr && region == RG_ERR && data_out[0])
        err_flag <= 1'b0;
    end
  end

  assign cfg_out = cfg_q;

  lb_rd_pipe #(
    .len   (read_pipe_len - 1),
    .width (32)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stage1_q),
    .q     (data_in)
  );

endmodule

// File: tb/tb_lb_reg_bank.sv
// Directed bench for lb_reg_bank: three instances (read latency 1, 3, 5)
// share one bus so latency and back-to-back behaviour can be compared side by side.
module tb_lb_reg_bank;

  localparam logic [31:0] ID   = 32'h4C425242;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;
  localparam logic [7:0]  PAGE = 8'h00;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [23:0]  addr;
  logic         control_strobe, control_rd, control_write;
  logic [31:0]  data_out;
  logic [255:0] stat_in;

  logic [31:0]  data_in1, data_in3, data_in5;
  logic [255:0] cfg1, cfg3, cfg5;
  logic [31:0]  pulse1, pulse3, pulse5;
  logic         err1, err3, err5;

  int           checks = 0;
  int           failures = 0;
  logic [15:0]  rd_exp = '0;
  logic [15:0]  wr_exp = '0;
  logic [255:0] exp_cfg = '0;

  always #5 clk = ~clk;

  lb_reg_bank #(.read_pipe_len(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .control_strobe(control_strobe),
    .control_rd(control_rd), .control_write(control_write), .data_out(data_out),
    .data_in(data_in1), .cfg_out(cfg1), .stat_in(stat_in), .pulse_out(pulse1),
    .err_flag(err1));

  lb_reg_bank #(.read_pipe_len(3)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .control_strobe(control_strobe),
    .control_rd(control_rd), .control_write(control_write), .data_out(data_out),
    .data_in(data_in3), .cfg_out(cfg3), .stat_in(stat_in), .pulse_out(pulse3),
    .err_flag(err3));

  lb_reg_bank #(.read_pipe_len(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .control_strobe(control_strobe),
    .control_rd(control_rd), .control_write(control_write), .data_out(data_out),
    .data_in(data_in5), .cfg_out(cfg5), .stat_in(stat_in), .pulse_out(pulse5),
    .err_flag(err5));

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe cycle; returns in cycle t+1 with the bus idle again.
  task automatic bus_op(input logic rd, input logic [23:0] a, input logic [31:0] d,
                        input logic illegal);
    @(negedge clk);
    addr = a; data_out = d;
    control_strobe = 1'b1; control_rd = rd; control_write = !rd || illegal;
    if (a[23:16] == PAGE) begin
      if (rd) rd_exp = rd_exp + 16'd1;
      else    wr_exp = wr_exp + 16'd1;
    end
    @(negedge clk);
    control_strobe = 1'b0; control_rd = 1'b0; control_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr = '0; data_out = '0;
    control_strobe = 1'b0; control_rd = 1'b0; control_write = 1'b0;
    for (int k = 0; k < 8; k++) stat_in[32*k +: 32] = 32'h5A000000 | k;
    idle(3);
    checks++; if ({cfg1, cfg3, cfg5} !== '0) begin failures++; $display("FAIL reset_cfg: got %h/%h/%h expected 0", cfg1, cfg3, cfg5); end
    checks++; if ({data_in1, data_in3, data_in5} !== '0) begin failures++; $display("FAIL reset_data_in: got %h %h %h expected 0", data_in1, data_in3, data_in5); end
    checks++; if ({pulse1, pulse3, pulse5} !== '0) begin failures++; $display("FAIL reset_pulse: got %h %h %h expected 0", pulse1, pulse3, pulse5); end
    checks++; if ({err1, err3, err5} !== 3'b000) begin failures++; $display("FAIL reset_err: got %b%b%b expected 000", err1, err3, err5); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_cfg_write();
    bus_op(1'b0, 24'h000003, DEAD, 1'b0);
    exp_cfg[127:96] = DEAD;
    checks++; if (cfg3 !== exp_cfg) begin failures++; $display("FAIL cfg_write: got %h expected %h", cfg3, exp_cfg); end
    idle(6);
    bus_op(1'b1, 24'h000003, '0, 1'b0);
    idle(1);
    checks++; if (data_in3 !== 32'h0) begin failures++; $display("FAIL cfg_read_early: got %h expected %h", data_in3, 32'h0); end
    idle(1);
    checks++; if (data_in3 !== DEAD) begin failures++; $display("FAIL cfg_read: got %h expected %h", data_in3, DEAD); end
  endtask

  task automatic test_latency();
    logic [31:0] e;
    idle(4);
    bus_op(1'b1, 24'h000080, '0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      e = (k >= 1) ? ID : DEAD;
      checks++; if (data_in1 !== e) begin failures++; $display("FAIL latency1 k=%0d: got %h expected %h", k, data_in1, e); end
      e = (k >= 3) ? ID : DEAD;
      checks++; if (data_in3 !== e) begin failures++; $display("FAIL latency3 k=%0d: got %h expected %h", k, data_in3, e); end
      e = (k >= 5) ? ID : DEAD;
      checks++; if (data_in5 !== e) begin failures++; $display("FAIL latency5 k=%0d: got %h expected %h", k, data_in5, e); end
      if (k < 5) idle(1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    @(negedge clk);
    addr = 24'h000003; control_strobe = 1'b1; control_rd = 1'b1; control_write = 1'b0;
    rd_exp = rd_exp + 16'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr = 24'h000080; rd_exp = rd_exp + 16'd1;
      end else if (k == 2) begin
        control_strobe = 1'b0; control_rd = 1'b0;
      end
      e = (k == 1) ? DEAD : ID;
      checks++; if (data_in1 !== e) begin failures++; $display("FAIL b2b1 k=%0d: got %h expected %h", k, data_in1, e); end
      e = (k == 3) ? DEAD : ID;
      checks++; if (data_in3 !== e) begin failures++; $display("FAIL b2b3 k=%0d: got %h expected %h", k, data_in3, e); end
      e = (k == 5) ? DEAD : ID;
      checks++; if (data_in5 !== e) begin failures++; $display("FAIL b2b5 k=%0d: got %h expected %h", k, data_in5, e); end
    end
  endtask

  task automatic test_pulse();
    bus_op(1'b0, 24'h0000C0, 32'h5, 1'b0);
    checks++; if (pulse3 !== 32'h5) begin failures++; $display("FAIL pulse_on: got %h expected %h", pulse3, 32'h5); end
    idle(1);
    checks++; if (pulse3 !== 32'h0) begin failures++; $display("FAIL pulse_off: got %h expected %h", pulse3, 32'h0); end
    bus_op(1'b1, 24'h0000C0, '0, 1'b0);
    idle(2);
    checks++; if (data_in3 !== 32'h0) begin failures++; $display("FAIL pulse_read: got %h expected %h", data_in3, 32'h0); end
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL pulse_read_err: got %b expected 0", err3); end
  endtask

  task automatic test_status();
    bus_op(1'b1, 24'h000042, '0, 1'b0);
    stat_in[95:64] = 32'h0;
    idle(2);
    checks++; if (data_in3 !== 32'h5A000002) begin failures++; $display("FAIL status_read: got %h expected %h", data_in3, 32'h5A000002); end
    stat_in[95:64] = 32'h5A000002;
  endtask

  task automatic test_err();
    bus_op(1'b0, 24'h000045, 32'h1234, 1'b0);
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL err_wr_ro: got %b expected 1", err3); end
    checks++; if (cfg3 !== exp_cfg) begin failures++; $display("FAIL err_cfg_kept: got %h expected %h", cfg3, exp_cfg); end
    bus_op(1'b0, 24'h000082, 32'h1, 1'b0);
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", err3); end
    bus_op(1'b1, 24'h000003, '0, 1'b0);
    bus_op(1'b1, 24'h000090, '0, 1'b0);
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL err_rd_unmapped: got %b expected 1", err3); end
    idle(1);
    checks++; if (data_in3 !== DEAD) begin failures++; $display("FAIL err_prev_read: got %h expected %h", data_in3, DEAD); end
    idle(1);
    checks++; if (data_in3 !== 32'h0) begin failures++; $display("FAIL err_rd_data: got %h expected %h", data_in3, 32'h0); end
    bus_op(1'b0, 24'h000182, 32'h1, 1'b0);
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL err_set_wins: got %b expected 1", err3); end
    bus_op(1'b0, 24'h000082, 32'h1, 1'b0);
    bus_op(1'b1, 24'h000080, '0, 1'b1);
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL err_illegal: got %b expected 1", err3); end
    idle(2);
    checks++; if (data_in3 !== ID) begin failures++; $display("FAIL err_illegal_data: got %h expected %h", data_in3, ID); end
    bus_op(1'b0, 24'h000082, 32'h1, 1'b0);
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL err_clear2: got %b expected 0", err3); end
  endtask

  task automatic test_wrong_page();
    logic [31:0] e;
    idle(4);
    bus_op(1'b0, 24'h010000, 32'hAAAA5555, 1'b0);
    checks++; if (cfg3 !== exp_cfg) begin failures++; $display("FAIL page_cfg: got %h expected %h", cfg3, exp_cfg); end
    bus_op(1'b1, 24'h010003, '0, 1'b0);
    idle(3);
    checks++; if (data_in3 !== ID) begin failures++; $display("FAIL page_data_in: got %h expected %h", data_in3, ID); end
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL page_err: got %b expected 0", err3); end
    e = {rd_exp, wr_exp};
    bus_op(1'b1, 24'h000081, '0, 1'b0);
    idle(2);
    checks++; if (data_in3 !== e) begin failures++; $display("FAIL page_counts: got %h expected %h", data_in3, e); end
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] e;
    n = 65536 - int'(wr_exp);
    @(negedge clk);
    addr = 24'h000007; data_out = 32'h77;
    control_strobe = 1'b1; control_rd = 1'b0; control_write = 1'b1;
    repeat (n) @(negedge clk);
    control_strobe = 1'b0; control_write = 1'b0;
    wr_exp = wr_exp + 16'(n);
    exp_cfg[255:224] = 32'h77;
    checks++; if (cfg3 !== exp_cfg) begin failures++; $display("FAIL wrap_cfg: got %h expected %h", cfg3, exp_cfg); end
    e = {rd_exp, 16'h0000};
    bus_op(1'b1, 24'h000081, '0, 1'b0);
    idle(2);
    checks++; if (data_in3 !== e) begin failures++; $display("FAIL wrap_counts: got %h expected %h", data_in3, e); end
  endtask

  task automatic test_reset_mid_read();
    bus_op(1'b1, 24'h000080, '0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_exp = '0; wr_exp = '0; exp_cfg = '0;
    checks++; if ({data_in1, data_in3, data_in5} !== '0) begin failures++; $display("FAIL midrst_data_in: got %h %h %h expected 0", data_in1, data_in3, data_in5); end
    checks++; if (cfg3 !== exp_cfg) begin failures++; $display("FAIL midrst_cfg: got %h expected %h", cfg3, exp_cfg); end
    idle(4);
    checks++; if ({data_in3, data_in5} !== '0) begin failures++; $display("FAIL midrst_flush: got %h %h expected 0", data_in3, data_in5); end
    bus_op(1'b0, 24'h000000, 32'h11, 1'b0);
    bus_op(1'b1, 24'h000081, '0, 1'b0);
    idle(2);
    checks++; if (data_in3 !== 32'h00000001) begin failures++; $display("FAIL midrst_counts: got %h expected %h", data_in3, 32'h00000001); end
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_latency();
    test_back_to_back();
    test_pulse();
    test_status();
    test_err();
    test_wrong_page();
    test_wrap();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lb_reg_bank.md
Name: lb_reg_bank

Overview:
Local-bus register bank that sits directly downstream of the UDP memory gateway. It decodes the gateway's addr/strobe/rd/data_out and answers reads on data_in with a fixed latency equal to the gateway's read_pipe_len. It provides:
- writable config registers,
- read-only status inputs,
- write-triggered pulse outputs,
- bus transaction counters and a sticky access-error flag.

Parameters:
- read_pipe_len, 3: cycles from the strobe cycle to the cycle data_in is valid. Minimum 1. Must equal the gateway's setting.
- page, 8'h00: addr[23:16] value this bank responds to.
- n_cfg, 8: number of 32-bit config registers, 1..64.
- n_stat, 8: number of 32-bit status inputs, 1..64.
- bank_id, 32'h4C425242: constant returned at ID address.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  synchronous reset, active low
- addr  in  24  local-bus address, valid on the strobe cycle
- control_strobe  in  1  one-cycle transaction marker
- control_rd  in  1  1 = read, 0 = write; level, qualified by strobe
- control_write  in  1  equals control_strobe & ~control_rd
- data_out  in  32  write data, valid on the strobe cycle
- data_in  out  32  read data toward the gateway
- cfg_out  out  n_cfg*32  config registers, reg k at [32k+31:32k]
- stat_in  in  n_stat*32  status words, sampled on the read strobe cycle
- pulse_out  out  32  one-cycle pulses
- err_flag  out  1  sticky access error

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: cfg_out = 0, pulse_out = 0, data_in = 0, err_flag = 0, counters = 0. Reset clears the read pipeline, so a read in flight at reset returns 0.
- Hit: control_strobe & (addr[23:16] == page). A non-hit is ignored entirely: no counter, no error, and data_in is unaffected.
- Address map, within page (a = addr[7:0]):
  - 0x00..0x3F config RW. Index ≥ n_cfg is unmapped.
  - 0x40..0x7F status RO. Index ≥ n_stat is unmapped.
  - 0x80: bank_id RO.
  - 0x81: {rd_count[15:0], wr_count[15:0]} RO.
  - 0x82: bit0 = err_flag. A write with data_out[0] = 1 clears it.
  - 0xC0: pulse register, write-only; reads return 0.
  - Everything else is unmapped.
  - addr[15:8] must be 0 for a hit to be mapped; otherwise it is unmapped.
- Write on strobe cycle t:
  - Config register takes data_out at edge t+1.
  - pulse_out = data_out for cycle t+1 only, then returns to 0.
- Error flag: a write to an RO or unmapped address is dropped and sets err_flag at t+1. A read from an unmapped address returns 0 and sets err_flag. If a clear and a set land on the same cycle, set wins.
- Counters: wr_count increments on each hit write, rd_count on each hit read. Both are 16 bit and wrap 0xFFFF → 0. A read of 0x81 returns the counts before that read's own increment.
- Read latency:
  - Strobe at cycle t. The registered mux result appears at t+1, then passes through read_pipe_len−1 further register stages.
  - data_in is valid during cycle t+read_pipe_len and holds until the next hit read's data replaces it.
  - Back-to-back reads every cycle must be supported (full pipeline).
- Read-after-write: a read strobed at t+1 or later returns the value written at t. Reading config returns the register contents, not a shadow.
- Status sampling: stat_in is captured on the read strobe cycle. There is no CDC inside this block; callers synchronise.
- Strobe with control_rd = 1 and control_write = 1 is illegal. It is treated as a read and sets err_flag.

Decomposition:
- Shared package lb_bank_pkg: region base constants (CFG_BASE 0x00, STAT_BASE 0x40, ID_ADDR 0x80, CNT_ADDR 0x81, ERR_ADDR 0x82, PULSE_ADDR 0xC0), the region select width, and the error-cause encoding.
- One natural sub-module, lb_rd_pipe: the read_pipe_len−1 stage data delay with synchronous active-low clear. It is parameterised by length and must handle length 0 as a passthrough.

Test Plan:
- Reset then write cfg[3] = 0xDEADBEEF at t → cfg_out[127:96] = 0xDEADBEEF from t+1. Read 0x03 at t+8 → data_in = 0xDEADBEEF exactly at t+8+read_pipe_len.
- Sweep read_pipe_len ∈ {1,3,5}: read 0x80 → data_in = 0x4C425242 on cycle t+read_pipe_len and not earlier. Back-to-back reads of 0x80 and 0x03 on consecutive cycles → two correct consecutive words.
- Write 0xC0 with 0x00000005 → pulse_out = 5 for exactly one cycle, then 0. Read 0xC0 → 0, err_flag stays 0.
- Write 0x45 (status), then read 0x90 → err_flag = 1, cfg_out unchanged, read returns 0. Write 0x82 = 1 → err_flag = 0. Clear on the same cycle as a new error → stays 1.
- Wrong page (addr[23:16] = page+1) write/read → no cfg change, counters unchanged, data_in unchanged.
- 65536 writes then read 0x81 → wr_count = 0x0000 (wrapped). Assert rst_n = 0 mid-read → data_in = 0 and all counters 0 next cycle.
